// File: rtl/uart_tx_sched.sv
// Round-robin share of one UART TX line between two byte requesters; 8N1, or 8E1 with UART_TX_PARITY_EN.
// Grant is combinational in IDLE, tx is registered (start bit from grant+1); requests wait while busy.
`timescale 1ns/1ps
module uart_tx_sched #(
    parameter int DATA_W        = 8,
    parameter int TICKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              owner
);
    localparam int CNT_W = $clog2(TICKS_PER_BIT) + 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign bit_end = tick && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        owner_d = owner_q;
        last_d  = last_q;
        tx_d    = tx_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Every state change coincides with a wrap, so the wrap doubles as the clear.
        if (state_q != S_IDLE && tick)
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                // No grant while reset is held, so requesters never see a phantom handshake.
                if (reset && (req0 || req1)) begin
                    if (req0 && (!req1 || last_q)) begin
                        gnt0    = 1'b1;
                        shift_d = data0;
                        owner_d = 1'b0;
                    end else begin
                        gnt1    = 1'b1;
                        shift_d = data1;
                        owner_d = 1'b1;
                    end
`ifdef UART_TX_PARITY_EN
                    par_d   = ^shift_d;
`endif
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: if (bit_end) begin
                idx_d   = '0;
                tx_d    = shift_q[0];
                state_d = S_DATA;
            end
            S_DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                    tx_d    = par_q;
                    state_d = S_PARITY;
`else
                    tx_d    = 1'b1;
                    state_d = S_STOP;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    tx_d  = shift_d[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) begin
                tx_d    = 1'b1;
                state_d = S_STOP;
            end
`endif
            S_STOP: if (bit_end) begin
                done    = 1'b1;
                last_d  = owner_q;
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: one instance at 1 tick/bit, one at 4 ticks/bit, scoreboarded frames.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    localparam int T1 = 1;
    localparam int T4 = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] rq = '0;
    logic [7:0] dt [4];
    logic [3:0] gnt_w;
    logic [1:0] tx_w, busy_w, done_w, own_w;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_sched #(.DATA_W(8), .TICKS_PER_BIT(T1)) u_dut (
        .clk(clk), .reset(reset), .tick(tick),
        .req0(rq[0]), .data0(dt[0]), .req1(rq[1]), .data1(dt[1]),
        .gnt0(gnt_w[0]), .gnt1(gnt_w[1]), .tx(tx_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .owner(own_w[0]));

    uart_tx_sched #(.DATA_W(8), .TICKS_PER_BIT(T4)) u_dut4 (
        .clk(clk), .reset(reset), .tick(tick),
        .req0(rq[2]), .data0(dt[2]), .req1(rq[3]), .data1(dt[3]),
        .gnt0(gnt_w[2]), .gnt1(gnt_w[3]), .tx(tx_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .owner(own_w[1]));

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Requester model: each port holds a FIFO of bytes, req high while non-empty.
    logic [7:0] dbuf [4][8];
    int         dhead [4];
    int         dtail [4];
    logic [3:0] gseen = '0;

    always @(negedge clk) gseen = gnt_w;

    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (gseen[i] && dhead[i] != dtail[i]) dhead[i]++;
            rq[i] = (dhead[i] != dtail[i]);
            dt[i] = rq[i] ? dbuf[i][dhead[i] % 8] : 8'h00;
        end
    end

    typedef struct packed {
        logic       inst;
        logic       own;
        logic [7:0] dat;
    } exp_t;
    exp_t sbq [$];

    task automatic push_req(input int inst, input int r, input logic [7:0] d);
        dbuf[inst*2+r][dtail[inst*2+r] % 8] = d;
        dtail[inst*2+r]++;
    endtask

    task automatic expect_frame(input int inst, input int own, input logic [7:0] d);
        exp_t e;
        e.inst = inst[0];
        e.own  = own[0];
        e.dat  = d;
        sbq.push_back(e);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && PAR) return ^d;
        return 1'b1;
    endfunction

    int   nsmp [2];
    logic smp  [2][64];
    int   nfr  [2];
    int   ngnt [2];
    logic dprev [2];

    task automatic frame_end(input int k);
        exp_t e;
        int   tpb;
        int   bad;
        nfr[k]++;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: inst %0d produced a frame, none expected", k);
        end else begin
            e   = sbq.pop_front();
            tpb = (k == 1) ? T4 : T1;
            chk("frame_inst", k, e.inst);
            chk("frame_owner", own_w[k], e.own);
            chk("frame_ticks", nsmp[k], NB * tpb);
            bad = 0;
            for (int i = 0; i < NB * tpb && i < 64; i++)
                if (smp[k][i] !== exp_bit(e.dat, i / tpb)) bad++;
            chk("frame_bits", bad, 0);
        end
        nsmp[k] = 0;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                nsmp[k] = 0;
                if (rq[2*k] | rq[2*k+1]) chk("gnt_in_reset", {gnt_w[2*k+1], gnt_w[2*k]}, 0);
            end else begin
                if (dprev[k]) chk("busy_after_done", busy_w[k], 0);
                if (gnt_w[2*k] | gnt_w[2*k+1]) begin
                    ngnt[k]++;
                    chk("gnt_exclusive", gnt_w[2*k] & gnt_w[2*k+1], 0);
                end
                if (busy_w[k] && tick) begin
                    if (nsmp[k] < 64) smp[k][nsmp[k]] = tx_w[k];
                    nsmp[k]++;
                end
                if (done_w[k]) frame_end(k);
            end
            dprev[k] = reset && done_w[k];
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dhead[i] = 0;
            dtail[i] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            nfr[k]  = 0;
            ngnt[k] = 0;
        end
        sbq.delete();
        cycles(3);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (sbq.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_timeout", sbq.size(), 0);
        cycles(3);
    endtask

    typedef struct {
        int          n0;
        int          n1;
        logic [15:0] d0;
        logic [15:0] d1;
        int          nf;
        logic [3:0]  own;
    } vec_t;
    vec_t tbl [5];

    initial begin
        int c0, c1, c;
        tbl[0] = '{1, 0, 16'h00A5, 16'h0000, 1, 4'b0000};
        tbl[1] = '{1, 1, 16'h000F, 16'h00F0, 2, 4'b0010};
        tbl[2] = '{2, 2, 16'h813C, 16'hFF5A, 4, 4'b1010};
        tbl[3] = '{0, 1, 16'h0000, 16'h0000, 1, 4'b0001};
        tbl[4] = '{0, 2, 16'h0000, 16'h077E, 2, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            dhead[i] = 0;
            dtail[i] = 0;
            dt[i]    = 8'h00;
        end
        for (int k = 0; k < 2; k++) begin
            nsmp[k] = 0; nfr[k] = 0; ngnt[k] = 0; dprev[k] = 1'b0;
        end

        cycles(3);
        chk("rst_tx", tx_w, 2'b11);
        chk("rst_busy", busy_w, 2'b00);
        chk("rst_done", done_w, 2'b00);
        chk("rst_owner", own_w, 2'b00);
        chk("rst_gnt", gnt_w, 4'b0000);
        reset = 1'b1;
        cycles(4);
        chk("idle_tx", tx_w, 2'b11);
        chk("idle_busy", busy_w, 2'b00);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int j = 0; j < tbl[v].n0; j++) push_req(0, 0, tbl[v].d0[j*8 +: 8]);
            for (int j = 0; j < tbl[v].n1; j++) push_req(0, 1, tbl[v].d1[j*8 +: 8]);
            c0 = 0;
            c1 = 0;
            for (int f = 0; f < tbl[v].nf; f++) begin
                if (tbl[v].own[f]) begin
                    expect_frame(0, 1, tbl[v].d1[c1*8 +: 8]);
                    c1++;
                end else begin
                    expect_frame(0, 0, tbl[v].d0[c0*8 +: 8]);
                    c0++;
                end
            end
            wait_drain(3000);
            chk("vec_frames", nfr[0], tbl[v].nf);
            chk("vec_grants", ngnt[0], tbl[v].nf);
        end

        // Four ticks per bit, byte 0x01.
        do_reset();
        push_req(1, 0, 8'h01);
        expect_frame(1, 0, 8'h01);
        wait_drain(3000);
        chk("t4_frames", nfr[1], 1);
        chk("t4_tx_idle", tx_w[1], 1'b1);

        // Reset during data bit 3, with requester 1 waiting through the reset.
        do_reset();
        push_req(0, 0, 8'hC3);
        c = 0;
        while (!busy_w[0] && c < 100) begin @(negedge clk); c++; end
        while (nsmp[0] < 4 && c < 500) begin @(negedge clk); c++; end
        chk("midrst_reached", nsmp[0], 4);
        cycles(2);
        #2 reset = 1'b0;
        #1;
        chk("midrst_tx", tx_w[0], 1'b1);
        chk("midrst_busy", busy_w[0], 1'b0);
        chk("midrst_done", done_w[0], 1'b0);
        push_req(0, 1, 8'h3C);
        expect_frame(0, 1, 8'h3C);
        cycles(4);
        reset = 1'b1;
        wait_drain(3000);
        chk("midrst_frames", nfr[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
